// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between the CPU memory port, the RAM and the I/O pins of mem_bus_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ready;
  logic              err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] sw_in;
  logic [DATA_W-1:0] led_out;

  modport slave (
    input  mem_cmd, mem_addr, mem_wdata, ram_rdata, sw_in,
    output mem_rdata, ready, err, ram_addr, ram_wdata, ram_we, led_out
  );

  modport master (
    output mem_cmd, mem_addr, mem_wdata, ram_rdata, sw_in,
    input  mem_rdata, ready, err, ram_addr, ram_wdata, ram_we, led_out
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory/I-O bus controller: latches a CPU request, waits out RAM read latency,
// decodes RAM / switch / LED windows and returns a one-cycle ready (plus err if unmapped).
module mem_bus_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1,
  parameter int IO_BASE     = 256
) (
  input logic           clk,
  input logic           reset,
  mem_bus_ctrl_if.slave bus
);

  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] SW_ADDR   = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] LED_ADDR  = ADDR_W'(IO_BASE + 1);
  localparam logic [1:0]        CMD_READ  = 2'b01;
  localparam logic [1:0]        CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic ram_hit(input logic [ADDR_W-1:0] a);
    return (a < SW_ADDR);
  endfunction

  // The switch is read-only and the LED latch write-only; the wrong direction is unmapped.
  function automatic logic unmapped(input logic [ADDR_W-1:0] a, input logic wr);
    return !(ram_hit(a) || ((a == SW_ADDR) && !wr) || ((a == LED_ADDR) && wr));
  endfunction

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              ram_we_q, ram_we_d;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      led_q    <= {DATA_W{1'b0}};
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      ram_we_q <= ram_we_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    led_d   = led_q;

    case (state_q)
      IDLE: begin
        if ((bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE)) begin
          wr_d    = (bus.mem_cmd == CMD_WRITE);
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          if ((bus.mem_cmd == CMD_READ) && ram_hit(bus.mem_addr)) begin
            cnt_d = WAIT_LOAD;
          end else begin
            cnt_d = {CNT_W{1'b0}};
          end
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = BUSY;
        end else begin
          if (!wr_q) begin
            if (ram_hit(addr_q)) begin
              rdata_d = bus.ram_rdata;
            end else if (!unmapped(addr_q, wr_q)) begin
              rdata_d = bus.sw_in;
            end else begin
              rdata_d = {DATA_W{1'b0}};
            end
          end else begin
            if (addr_q == LED_ADDR) begin
              led_d = wdata_q;
            end else begin
              led_d = led_q;
            end
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    ready_d  = (state_d == DONE);
    err_d    = (state_d == DONE) && unmapped(addr_q, wr_q);
    ram_we_d = (state_d == BUSY) && wr_d && ram_hit(addr_d);
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.led_out   = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a WAIT_CYCLES=1 instance with a synchronous RAM
// model, plus WAIT_CYCLES=0 and 3 instances for the latency sweep.
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(9)) bus1 ();
  mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(9)) bus0 ();
  mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(9)) bus3 ();

  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(9), .WAIT_CYCLES(1), .IO_BASE(256))
    u_dut (.clk(clk), .reset(rst), .bus(bus1));
  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(9), .WAIT_CYCLES(0), .IO_BASE(256))
    u_w0 (.clk(clk), .reset(rst), .bus(bus0));
  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(9), .WAIT_CYCLES(3), .IO_BASE(256))
    u_w3 (.clk(clk), .reset(rst), .bus(bus3));

  typedef struct {
    logic [15:0] rd;
    logic        e;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [15:0] ram_mem [0:511];
  logic        seed_en;
  logic [8:0]  seed_addr;
  logic [15:0] seed_data;
  int          we_cnt = 0;
  logic [8:0]  we_addr;
  logic [15:0] we_data;

  always @(posedge clk) begin
    if (seed_en) ram_mem[seed_addr] <= seed_data;
    else if (bus1.ram_we) ram_mem[bus1.ram_addr] <= bus1.ram_wdata;
    bus1.ram_rdata <= ram_mem[bus1.ram_addr];
  end

  always @(negedge clk) begin
    if (bus1.ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= bus1.ram_addr;
      we_data <= bus1.ram_wdata;
    end
  end

  assign bus0.ram_rdata = {7'd0, bus0.ram_addr} ^ 16'hC3C3;
  assign bus3.ram_rdata = {7'd0, bus3.ram_addr} ^ 16'hC3C3;

  task automatic issue(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                       input logic glitch, output int lat, output logic [15:0] rd,
                       output logic e, output logic to);
    @(negedge clk);
    bus1.mem_cmd = cmd; bus1.mem_addr = addr; bus1.mem_wdata = wd;
    @(posedge clk);
    lat = 0; rd = 16'h0000; e = 1'b0; to = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (glitch && i == 1) begin
        bus1.mem_cmd = 2'b10; bus1.mem_addr = 9'd300; bus1.mem_wdata = 16'hDEAD;
      end
      if (bus1.ready) begin
        lat = i; rd = bus1.mem_rdata; e = bus1.err; to = 1'b0;
        break;
      end
    end
    bus1.mem_cmd = 2'b00;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 7;
    if (bus1.mem_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", bus1.mem_rdata); end
    if (bus1.ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus1.ready); end
    if (bus1.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus1.err); end
    if (bus1.ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus1.ram_we); end
    if (bus1.led_out !== 16'h0000) begin bad++; $display("FAIL rst_led got=%h exp=0000", bus1.led_out); end
    if (bus1.ram_addr !== 9'd0) begin bad++; $display("FAIL rst_ram_addr got=%0d exp=0", bus1.ram_addr); end
    if (bus1.ram_wdata !== 16'h0000) begin bad++; $display("FAIL rst_ram_wdata got=%h exp=0000", bus1.ram_wdata); end
  endtask

  task automatic test_ram_read;
    int lat; logic [15:0] rd; logic e, to; exp_t x;
    sb.push_back('{rd: 16'hABCD, e: 1'b0, lat: 3});
    issue(2'b01, 9'd5, 16'h0000, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    total += 4;
    if (to || lat !== x.lat) begin bad++; $display("FAIL rd5_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL rd5_data got=%h exp=%h", rd, x.rd); end
    if (e !== x.e) begin bad++; $display("FAIL rd5_err got=%b exp=%b", e, x.e); end
    if (bus1.ram_addr !== 9'd5) begin bad++; $display("FAIL rd5_ram_addr got=%0d exp=5", bus1.ram_addr); end
  endtask

  task automatic test_ram_write;
    int lat, base; logic [15:0] rd; logic e, to; exp_t x;
    base = we_cnt;
    sb.push_back('{rd: 16'hABCD, e: 1'b0, lat: 2});
    issue(2'b10, 9'd7, 16'h1234, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    @(negedge clk);
    total += 6;
    if (to || lat !== x.lat) begin bad++; $display("FAIL wr7_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL wr7_rdata_held got=%h exp=%h", rd, x.rd); end
    if (e !== x.e) begin bad++; $display("FAIL wr7_err got=%b exp=%b", e, x.e); end
    if (we_cnt - base !== 1) begin bad++; $display("FAIL wr7_we_cycles got=%0d exp=1", we_cnt - base); end
    if (we_addr !== 9'd7) begin bad++; $display("FAIL wr7_we_addr got=%0d exp=7", we_addr); end
    if (we_data !== 16'h1234) begin bad++; $display("FAIL wr7_we_data got=%h exp=1234", we_data); end
    sb.push_back('{rd: 16'h1234, e: 1'b0, lat: 3});
    issue(2'b01, 9'd7, 16'h0000, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    total += 2;
    if (to || lat !== x.lat) begin bad++; $display("FAIL rd7_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL rd7_data got=%h exp=%h", rd, x.rd); end
  endtask

  task automatic test_io;
    int lat, base; logic [15:0] rd; logic e, to; exp_t x;
    base = we_cnt;
    bus1.sw_in = 16'h0055;
    sb.push_back('{rd: 16'h1234, e: 1'b0, lat: 2});
    sb.push_back('{rd: 16'h0055, e: 1'b0, lat: 2});
    issue(2'b10, 9'd257, 16'h00FF, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    total += 4;
    if (to || lat !== x.lat) begin bad++; $display("FAIL led_lat got=%0d exp=%0d", lat, x.lat); end
    if (e !== x.e) begin bad++; $display("FAIL led_err got=%b exp=%b", e, x.e); end
    if (rd !== x.rd) begin bad++; $display("FAIL led_rdata_held got=%h exp=%h", rd, x.rd); end
    if (bus1.led_out !== 16'h00FF) begin bad++; $display("FAIL led_val got=%h exp=00ff", bus1.led_out); end
    issue(2'b01, 9'd256, 16'h0000, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    @(negedge clk);
    total += 4;
    if (to || lat !== x.lat) begin bad++; $display("FAIL sw_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL sw_data got=%h exp=%h", rd, x.rd); end
    if (e !== x.e) begin bad++; $display("FAIL sw_err got=%b exp=%b", e, x.e); end
    if (we_cnt !== base) begin bad++; $display("FAIL io_we got=%0d exp=%0d", we_cnt, base); end
  endtask

  task automatic test_unmapped;
    int lat, base; logic [15:0] rd; logic e, to; exp_t x;
    base = we_cnt;
    sb.push_back('{rd: 16'h0000, e: 1'b1, lat: 2});
    sb.push_back('{rd: 16'h0000, e: 1'b1, lat: 2});
    issue(2'b01, 9'd258, 16'h0000, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    total += 3;
    if (to || lat !== x.lat) begin bad++; $display("FAIL unm_rd_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL unm_rd_data got=%h exp=%h", rd, x.rd); end
    if (e !== x.e) begin bad++; $display("FAIL unm_rd_err got=%b exp=%b", e, x.e); end
    issue(2'b10, 9'd256, 16'hAAAA, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    @(negedge clk);
    total += 4;
    if (to || lat !== x.lat) begin bad++; $display("FAIL unm_wr_lat got=%0d exp=%0d", lat, x.lat); end
    if (e !== x.e) begin bad++; $display("FAIL unm_wr_err got=%b exp=%b", e, x.e); end
    if (bus1.led_out !== 16'h00FF) begin bad++; $display("FAIL unm_led got=%h exp=00ff", bus1.led_out); end
    if (we_cnt !== base) begin bad++; $display("FAIL unm_we got=%0d exp=%0d", we_cnt, base); end
  endtask

  task automatic test_reserved;
    int readies, base;
    base = we_cnt; readies = 0;
    @(negedge clk);
    bus1.mem_cmd = 2'b11; bus1.mem_addr = 9'd5;
    repeat (10) begin
      @(negedge clk);
      if (bus1.ready) readies++;
    end
    bus1.mem_cmd = 2'b00;
    total += 2;
    if (readies !== 0) begin bad++; $display("FAIL rsv_ready got=%0d exp=0", readies); end
    if (we_cnt !== base) begin bad++; $display("FAIL rsv_we got=%0d exp=%0d", we_cnt, base); end
  endtask

  task automatic test_busy_change;
    int lat, base; logic [15:0] rd; logic e, to; exp_t x;
    base = we_cnt;
    sb.push_back('{rd: 16'hABCD, e: 1'b0, lat: 3});
    issue(2'b01, 9'd5, 16'h0000, 1'b1, lat, rd, e, to);
    x = sb.pop_front();
    @(negedge clk);
    total += 4;
    if (to || lat !== x.lat) begin bad++; $display("FAIL chg_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL chg_data got=%h exp=%h", rd, x.rd); end
    if (e !== x.e) begin bad++; $display("FAIL chg_err got=%b exp=%b", e, x.e); end
    if (we_cnt !== base) begin bad++; $display("FAIL chg_we got=%0d exp=%0d", we_cnt, base); end
  endtask

  task automatic test_reset_mid_busy;
    int lat, base; logic [15:0] rd; logic e, to, saw; exp_t x;
    base = we_cnt;
    @(negedge clk);
    bus1.mem_cmd = 2'b10; bus1.mem_addr = 9'd9; bus1.mem_wdata = 16'h5A5A;
    @(posedge clk);
    #2;
    total += 1;
    if (bus1.ram_we !== 1'b1) begin bad++; $display("FAIL mid_we_pre got=%b exp=1", bus1.ram_we); end
    rst = 1'b1;
    #1;
    total += 2;
    if (bus1.ram_we !== 1'b0) begin bad++; $display("FAIL mid_we_fall got=%b exp=0", bus1.ram_we); end
    if (bus1.ram_addr !== 9'd0) begin bad++; $display("FAIL mid_ram_addr got=%0d exp=0", bus1.ram_addr); end
    bus1.mem_cmd = 2'b00;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus1.ready) saw = 1'b1;
    end
    total += 3;
    if (saw !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", saw); end
    if (bus1.led_out !== 16'h0000) begin bad++; $display("FAIL mid_led got=%h exp=0000", bus1.led_out); end
    if (we_cnt !== base) begin bad++; $display("FAIL mid_we_cnt got=%0d exp=%0d", we_cnt, base); end
    rst = 1'b0;
    sb.push_back('{rd: 16'hABCD, e: 1'b0, lat: 3});
    issue(2'b01, 9'd5, 16'h0000, 1'b0, lat, rd, e, to);
    x = sb.pop_front();
    total += 2;
    if (to || lat !== x.lat) begin bad++; $display("FAIL mid_rd_lat got=%0d exp=%0d", lat, x.lat); end
    if (rd !== x.rd) begin bad++; $display("FAIL mid_rd_data got=%h exp=%h", rd, x.rd); end
  endtask

  task automatic test_wait_sweep;
    int lat0, lat3; logic [15:0] rd0, rd3; logic e0, e3; exp_t x;
    sb.push_back('{rd: 16'hC3D7, e: 1'b0, lat: 2});
    sb.push_back('{rd: 16'hC3D7, e: 1'b0, lat: 5});
    @(negedge clk);
    bus0.mem_cmd = 2'b01; bus0.mem_addr = 9'd20;
    bus3.mem_cmd = 2'b01; bus3.mem_addr = 9'd20;
    @(posedge clk);
    lat0 = 0; lat3 = 0; rd0 = 16'h0000; rd3 = 16'h0000; e0 = 1'b0; e3 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (lat0 == 0 && bus0.ready) begin
        lat0 = i; rd0 = bus0.mem_rdata; e0 = bus0.err; bus0.mem_cmd = 2'b00;
      end
      if (lat3 == 0 && bus3.ready) begin
        lat3 = i; rd3 = bus3.mem_rdata; e3 = bus3.err; bus3.mem_cmd = 2'b00;
      end
      if (lat0 != 0 && lat3 != 0) break;
    end
    bus0.mem_cmd = 2'b00; bus3.mem_cmd = 2'b00;
    x = sb.pop_front();
    total += 3;
    if (lat0 !== x.lat) begin bad++; $display("FAIL w0_lat got=%0d exp=%0d", lat0, x.lat); end
    if (rd0 !== x.rd) begin bad++; $display("FAIL w0_data got=%h exp=%h", rd0, x.rd); end
    if (e0 !== x.e) begin bad++; $display("FAIL w0_err got=%b exp=%b", e0, x.e); end
    x = sb.pop_front();
    total += 3;
    if (lat3 !== x.lat) begin bad++; $display("FAIL w3_lat got=%0d exp=%0d", lat3, x.lat); end
    if (rd3 !== x.rd) begin bad++; $display("FAIL w3_data got=%h exp=%h", rd3, x.rd); end
    if (e3 !== x.e) begin bad++; $display("FAIL w3_err got=%b exp=%b", e3, x.e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    seed_en = 1'b1; seed_addr = 9'd5; seed_data = 16'hABCD;
    bus1.mem_cmd = 2'b00; bus1.mem_addr = 9'd0; bus1.mem_wdata = 16'h0000; bus1.sw_in = 16'h0000;
    bus0.mem_cmd = 2'b00; bus0.mem_addr = 9'd0; bus0.mem_wdata = 16'h0000; bus0.sw_in = 16'h0000;
    bus3.mem_cmd = 2'b00; bus3.mem_addr = 9'd0; bus3.mem_wdata = 16'h0000; bus3.sw_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    seed_en = 1'b0;
    rst = 1'b0;
    test_reset();
    test_ram_read();
    test_ram_write();
    test_io();
    test_unmapped();
    test_reserved();
    test_busy_change();
    test_reset_mid_busy();
    test_wait_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Parametrised memory/I-O bus controller between the CPU memory port (mem_cmd, mem_addr, write data) and a synchronous RAM plus a small memory-mapped I/O window.
- Successor to the fixed single-cycle memory hookup. Adds:
  - configurable data/address widths;
  - programmable RAM read wait states;
  - an I/O address window (switch input, LED output latch);
  - a ready handshake the CPU stalls on;
  - an error pulse for unmapped accesses.

Parameters:
- DATA_W, 16, width of data bus, RAM words, switch input and LED latch.
- ADDR_W, 9, width of mem_addr and ram_addr.
- WAIT_CYCLES, 1, extra cycles RAM read data needs after address is presented (0..15).
- IO_BASE, 256, first I/O address. Addresses below IO_BASE map to RAM.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_cmd  in  2  00=NONE, 01=READ, 10=WRITE, 11=reserved (treated as NONE).
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid while ready=1 after a read, held until the next read completes.
- ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with ready, for an unmapped access.
- ram_addr  out  ADDR_W  RAM address (latched request address).
- ram_wdata  out  DATA_W  RAM write data (latched).
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data.
- sw_in  in  DATA_W  switch input, read at address IO_BASE.
- led_out  out  DATA_W  LED latch, written at address IO_BASE+1.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state returns to IDLE and the pending request is dropped;
  - mem_rdata=0, ready=0, err=0, ram_we=0, led_out=0, ram_addr=0, ram_wdata=0, wait counter=0.
- Address decode, performed on the latched address:
  - RAM: addr < IO_BASE.
  - SW: addr == IO_BASE, read-only.
  - LED: addr == IO_BASE+1, write-only.
  - Anything else is unmapped, as are a write to SW and a read from LED.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Outputs: ready=0, err=0, ram_we=0.
  - On a clock edge with mem_cmd = READ or WRITE: latch cmd, addr and wdata; load counter = WAIT_CYCLES for a RAM read, else 0; go to BUSY.
  - NONE or 11: stay in IDLE.
- BUSY:
  - mem_cmd and mem_addr changes are ignored.
  - ram_addr and ram_wdata come from the latched values.
  - ram_we=1 only for a RAM write, in the single BUSY cycle.
  - If counter != 0: decrement and stay in BUSY.
  - If counter == 0, at the edge:
    - read: mem_rdata <= ram_rdata (RAM), sw_in (SW) or 0 (unmapped);
    - write to LED: led_out <= latched wdata;
    - writes to RAM/LED are not performed when unmapped;
    - go to DONE.
- DONE:
  - ready=1 for exactly one cycle; err=1 in the same cycle if unmapped.
  - Unconditionally returns to IDLE; no request is accepted in DONE.
- Latency, counting from the edge that samples the command:
  - ready is high in cycle WAIT_CYCLES+2 for RAM reads;
  - cycle 2 for all other accesses.
  - Back-to-back requests are spaced at least one IDLE cycle apart.
- The CPU must hold mem_cmd until it sees ready. A command still asserted in IDLE after ready is a new request.
- Counter width: max(1, $clog2(WAIT_CYCLES+1)). WAIT_CYCLES=0 gives a minimum RAM read latency of 2.
- A mem_rdata value from a read persists across intervening writes.

Test Plan:
- Reset asserted mid-BUSY with a RAM write pending (WAIT_CYCLES=1) -> ram_we falls immediately, no ready pulse, led_out=0, state IDLE; a subsequent read still works.
- RAM read of addr 5 with ram_rdata model returning 16'hABCD, WAIT_CYCLES=1 -> ram_addr=5, ready high exactly 3 cycles after the sampling edge, mem_rdata=16'hABCD, err=0.
- RAM write of 16'h1234 to addr 7 -> ram_we=1 for exactly one cycle with ram_addr=7 and ram_wdata=16'h1234; ready 2 cycles after sampling; mem_rdata unchanged.
- Write 16'h00FF to IO_BASE+1, then read IO_BASE with sw_in=16'h0055:
  - led_out=16'h00FF and ram_we never asserted;
  - the read returns 16'h0055 with latency 2.
- Unmapped accesses: read IO_BASE+2, then write IO_BASE:
  - each gives err=1 and ready=1 in the same cycle;
  - the read returns 0, led_out is unchanged, ram_we stays 0.
- Sweep WAIT_CYCLES=0 and 3: RAM read latency = 2 and 5 respectively. mem_cmd=11 for 10 cycles gives no ready. A mem_cmd change during BUSY does not alter the completed transaction.
